// File: rtl/pc_sequencer.sv
// Next-PC sequencer with BOOT/RUN/HALTED control and an optional return-address stack.
// Build with PC_SEQ_RAS_EN defined to include the stack and its call/ret behaviour.
module pc_sequencer #(
    parameter logic [7:0] RESET_VECTOR = 8'h00,
    parameter int         RAS_DEPTH    = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] valorPC,
    input  logic       stall,
    input  logic       halt,
    input  logic       resume,
    input  logic       branch_taken,
    input  logic [7:0] branch_offset,
    input  logic       jump,
    input  logic [7:0] jump_target,
    input  logic       call,
    input  logic       ret,
    output logic [7:0] valorEntradaPC,
    output logic       fetch_valid,
    output logic       halted,
    output logic       ras_overflow,
    output logic       ras_underflow
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] w_pc_inc;
    logic [7:0] w_pc_branch;
    logic       w_run_flow;

    assign w_pc_inc    = valorPC + 8'd1;
    // An 8-bit wrap-around add is identical to adding the sign-extended offset.
    assign w_pc_branch = valorPC + branch_offset;
    assign w_run_flow  = (r_state == ST_RUN) && !stall && !halt;

`ifdef PC_SEQ_RAS_EN
    localparam int IDX_W = $clog2(RAS_DEPTH);
    localparam int SP_W  = IDX_W + 1;

    logic [7:0]       r_stack [RAS_DEPTH];
    logic [SP_W-1:0]  r_sp;
    logic             r_ovf;
    logic             r_unf;
    logic             w_full;
    logic             w_empty;
    logic [IDX_W-1:0] w_top_idx;
    logic [7:0]       w_top;
    logic             w_push;
    logic             w_pop;
    logic             w_ovf_set;
    logic             w_unf_set;

    assign w_full    = (r_sp == SP_W'(RAS_DEPTH));
    assign w_empty   = (r_sp == {SP_W{1'b0}});
    assign w_top_idx = IDX_W'(r_sp - SP_W'(1));
    assign w_top     = r_stack[w_top_idx];

    // Stack request decode; ret outranks call, and full/empty turn requests into error flags.
    always_comb begin
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;
        if (w_run_flow && ret) begin
            if (w_empty) begin
                w_unf_set = 1'b1;
            end else begin
                w_pop = 1'b1;
            end
        end else if (w_run_flow && call) begin
            if (w_full) begin
                w_ovf_set = 1'b1;
            end else begin
                w_push = 1'b1;
            end
        end else begin
            w_push = 1'b0;
        end
    end

    // Stack storage and pointer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sp <= {SP_W{1'b0}};
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_stack[i] <= 8'h00;
            end
        end else if (w_push) begin
            r_stack[r_sp[IDX_W-1:0]] <= w_pc_inc;
            r_sp                     <= r_sp + SP_W'(1);
        end else if (w_pop) begin
            r_sp <= r_sp - SP_W'(1);
        end else begin
            r_sp <= r_sp;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= r_ovf | w_ovf_set;
            r_unf <= r_unf | w_unf_set;
        end
    end

    assign ras_overflow  = r_ovf;
    assign ras_underflow = r_unf;
`else
    assign ras_overflow  = 1'b0;
    assign ras_underflow = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (stall) begin
                    w_state_nxt = ST_RUN;
                end else if (halt) begin
                    w_state_nxt = ST_HALTED;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (resume) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_HALTED;
                end
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    // Output logic: next PC by priority, plus fetch/halt status.
    always_comb begin
        valorEntradaPC = RESET_VECTOR;
        fetch_valid    = 1'b0;
        halted         = 1'b0;
        case (r_state)
            ST_BOOT: begin
                valorEntradaPC = RESET_VECTOR;
            end
            ST_RUN: begin
                fetch_valid = 1'b1;
                if (stall || halt) begin
                    valorEntradaPC = valorPC;
                end else if (ret) begin
`ifdef PC_SEQ_RAS_EN
                    if (w_empty) begin
                        valorEntradaPC = w_pc_inc;
                    end else begin
                        valorEntradaPC = w_top;
                    end
`else
                    valorEntradaPC = w_pc_inc;
`endif
                end else if (call || jump) begin
                    valorEntradaPC = jump_target;
                end else if (branch_taken) begin
                    valorEntradaPC = w_pc_branch;
                end else begin
                    valorEntradaPC = w_pc_inc;
                end
            end
            ST_HALTED: begin
                halted = 1'b1;
                if (resume) begin
                    valorEntradaPC = w_pc_inc;
                end else begin
                    valorEntradaPC = valorPC;
                end
            end
            default: begin
                valorEntradaPC = RESET_VECTOR;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench: the driver queues hand-computed expectations, a negedge monitor checks them.
module tb_pc_sequencer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] valorPC;
    logic       stall, halt, resume, branch_taken, jump, call, ret;
    logic [7:0] branch_offset, jump_target;
    logic [7:0] valorEntradaPC;
    logic       fetch_valid, halted, ras_overflow, ras_underflow;

    typedef struct {
        logic [7:0] nxt;
        logic       fv;
        logic       h;
        logic       ov;
        logic       un;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic sim_done = 1'b0;

`ifdef PC_SEQ_RAS_EN
    localparam logic RAS = 1'b1;
`else
    localparam logic RAS = 1'b0;
`endif

    pc_sequencer dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .valorPC        (valorPC),
        .stall          (stall),
        .halt           (halt),
        .resume         (resume),
        .branch_taken   (branch_taken),
        .branch_offset  (branch_offset),
        .jump           (jump),
        .jump_target    (jump_target),
        .call           (call),
        .ret            (ret),
        .valorEntradaPC (valorEntradaPC),
        .fetch_valid    (fetch_valid),
        .halted         (halted),
        .ras_overflow   (ras_overflow),
        .ras_underflow  (ras_underflow)
    );

    always #5 clock = ~clock;

    // Monitor: the outputs are combinational, so every cycle with a queued expectation is compared.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (valorEntradaPC !== e.nxt || fetch_valid !== e.fv || halted !== e.h ||
                ras_overflow !== e.ov || ras_underflow !== e.un) begin
                n_errors++;
                $display("FAIL %s: got next=%h fv=%b halted=%b ovf=%b unf=%b, expected next=%h fv=%b halted=%b ovf=%b unf=%b",
                         e.name, valorEntradaPC, fetch_valid, halted, ras_overflow, ras_underflow,
                         e.nxt, e.fv, e.h, e.ov, e.un);
            end
        end
    end

    // Watchdog: the run must finish before the deadline expires.
    initial begin
        #100000;
        if (!sim_done) begin
            n_errors++;
            $display("FAIL timeout: simulation did not finish before the deadline");
            $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
            $finish;
        end
    end

    task automatic check_now(input string name);
        n_checks++;
        if (valorEntradaPC !== 8'h00 || fetch_valid !== 1'b0 || halted !== 1'b0 ||
            ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin
            n_errors++;
            $display("FAIL %s: immediate reset state wrong: next=%h fv=%b halted=%b ovf=%b unf=%b",
                     name, valorEntradaPC, fetch_valid, halted, ras_overflow, ras_underflow);
        end
    endtask

    task automatic cyc(input logic [7:0] pc);
        @(posedge clock);
        #1;
        valorPC       = pc;
        stall         = 1'b0;
        halt          = 1'b0;
        resume        = 1'b0;
        branch_taken  = 1'b0;
        branch_offset = 8'h00;
        jump          = 1'b0;
        jump_target   = 8'h00;
        call          = 1'b0;
        ret           = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [7:0] nxt, input logic fv,
                              input logic h, input logic ov, input logic un);
        exp_t e;
        e.nxt  = nxt;
        e.fv   = fv;
        e.h    = h;
        e.ov   = ov;
        e.un   = un;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic do_call(input logic [7:0] pc, input logic [7:0] tgt, input string name,
                           input logic ov, input logic un);
        cyc(pc);
        call        = 1'b1;
        jump_target = tgt;
        expect_out(name, tgt, 1'b1, 1'b0, ov, un);
    endtask

    task automatic do_ret(input logic [7:0] pc, input logic [7:0] nxt, input string name,
                          input logic ov, input logic un);
        cyc(pc);
        ret = 1'b1;
        expect_out(name, nxt, 1'b1, 1'b0, ov, un);
    endtask

    initial begin
        reset_n = 1'b0;
        cyc(8'h00);
        check_now("por_immediate");
        expect_out("in_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(8'h00);
        reset_n = 1'b1;
        expect_out("boot", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(8'h00); expect_out("inc0", 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(8'h01); expect_out("inc1", 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(8'h02); expect_out("inc2", 8'h03, 1'b1, 1'b0, 1'b0, 1'b0);

        cyc(8'h10); branch_taken = 1'b1; branch_offset = 8'hF0;
        expect_out("branch_back", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(8'h02); branch_taken = 1'b1; branch_offset = 8'hFC;
        expect_out("branch_neg4", 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(8'h70); branch_taken = 1'b1; branch_offset = 8'h05;
        expect_out("branch_fwd", 8'h75, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(8'hFF); expect_out("inc_wrap", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(8'h33); jump = 1'b1; jump_target = 8'h77; branch_taken = 1'b1; branch_offset = 8'h01;
        expect_out("jump_over_branch", 8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(8'h50); stall = 1'b1; jump = 1'b1; jump_target = 8'h99; halt = 1'b1;
        expect_out("stall_prio", 8'h50, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(8'h50); expect_out("after_stall", 8'h51, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef PC_SEQ_RAS_EN
        do_call(8'h05, 8'h40, "call1", 1'b0, 1'b0);
        do_call(8'h41, 8'h60, "call2", 1'b0, 1'b0);
        do_ret(8'h60, 8'h42, "ret1", 1'b0, 1'b0);
        do_ret(8'h43, 8'h06, "ret2", 1'b0, 1'b0);
        do_call(8'h10, 8'h30, "call_pre", 1'b0, 1'b0);
        cyc(8'h30); call = 1'b1; ret = 1'b1; jump_target = 8'h99;
        expect_out("call_and_ret", 8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
        do_call(8'h00, 8'hA0, "fill1", 1'b0, 1'b0);
        do_call(8'hA0, 8'hB0, "fill2", 1'b0, 1'b0);
        do_call(8'hB0, 8'hC0, "fill3", 1'b0, 1'b0);
        do_call(8'hC0, 8'hD0, "fill4", 1'b0, 1'b0);
        do_call(8'hD0, 8'hE0, "call_full", 1'b0, 1'b0);
        do_ret(8'hE0, 8'hC1, "pop1", 1'b1, 1'b0);
        do_ret(8'hC1, 8'hB1, "pop2", 1'b1, 1'b0);
        do_ret(8'hB1, 8'hA1, "pop3", 1'b1, 1'b0);
        do_ret(8'hA1, 8'h01, "pop4", 1'b1, 1'b0);
        do_ret(8'h01, 8'h02, "pop_empty", 1'b1, 1'b0);
        cyc(8'h02); expect_out("flags_sticky", 8'h03, 1'b1, 1'b0, 1'b1, 1'b1);
`else
        do_call(8'h05, 8'h40, "call_as_jump", 1'b0, 1'b0);
        do_ret(8'h40, 8'h41, "ret_as_inc", 1'b0, 1'b0);
        cyc(8'h30); call = 1'b1; ret = 1'b1; jump_target = 8'h99;
        expect_out("call_and_ret", 8'h31, 1'b1, 1'b0, 1'b0, 1'b0);
        do_ret(8'h01, 8'h02, "ret_no_flag", 1'b0, 1'b0);
`endif

        // Halt/resume; the sticky flags from the stack section stay visible.
        cyc(8'h20); halt = 1'b1; jump = 1'b1; jump_target = 8'h55;
        expect_out("halt", 8'h20, 1'b1, 1'b0, RAS, RAS);
        for (int i = 0; i < 3; i++) begin
            cyc(8'h20); jump = 1'b1; jump_target = 8'h55; call = 1'b1; branch_taken = 1'b1;
            expect_out("halted_hold", 8'h20, 1'b0, 1'b1, RAS, RAS);
        end
        cyc(8'h20); resume = 1'b1; jump = 1'b1; jump_target = 8'h55;
        expect_out("resume", 8'h21, 1'b0, 1'b1, RAS, RAS);
        cyc(8'h21); expect_out("run_after_resume", 8'h22, 1'b1, 1'b0, RAS, RAS);

        // Reset while halted with two stack entries.
        do_call(8'h05, 8'h40, "rcall1", RAS, RAS);
        do_call(8'h41, 8'h60, "rcall2", RAS, RAS);
        cyc(8'h60); halt = 1'b1;
        expect_out("rhalt", 8'h60, 1'b1, 1'b0, RAS, RAS);
        cyc(8'h60); expect_out("rhalted", 8'h60, 1'b0, 1'b1, RAS, RAS);
        cyc(8'h60); jump = 1'b1; jump_target = 8'h55;
        reset_n = 1'b0;
        #1;
        check_now("reset_halted_immediate");
        expect_out("reset_halted", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(8'h60);
        reset_n = 1'b1;
        expect_out("reboot", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        do_ret(8'h00, 8'h01, "ret_after_reset", 1'b0, 1'b0);
        cyc(8'h01); expect_out("unf_after_reset", 8'h02, 1'b1, 1'b0, 1'b0, RAS);

        cyc(8'h02);
        cyc(8'h02);
        sim_done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
